// File: rtl/wb_stage.sv
// Writeback stage: holds one instruction from MEM, aligns and extends load data,
// and drives the regfile write port, the ID bypass tuple and the debug trace.
module wb_stage #(
  parameter int unsigned           PC_W     = 32,
  parameter logic [PC_W-1:0]       RESET_PC = '0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            ms_to_ws_valid,
  output logic            ws_allowin,
  input  logic [PC_W-1:0] ms_pc,
  input  logic            ms_gr_we,
  input  logic [4:0]      ms_dest,
  input  logic [31:0]     ms_result,
  input  logic [2:0]      ms_load_op,
  input  logic [1:0]      ms_addr_low,
  input  logic [31:0]     ms_mem_rdata,
  input  logic            ws_stall,
  input  logic            ws_flush,
  output logic [3:0]      rf_we,
  output logic [4:0]      rf_waddr,
  output logic [31:0]     rf_wdata,
  output logic            ws_fwd_valid,
  output logic [4:0]      ws_fwd_dest,
  output logic [31:0]     ws_fwd_data,
  output logic [PC_W-1:0] debug_wb_pc,
  output logic [3:0]      debug_wb_rf_wen,
  output logic [4:0]      debug_wb_rf_wnum,
  output logic [31:0]     debug_wb_rf_wdata
);

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_B    = 3'd1,
    LD_BU   = 3'd2,
    LD_H    = 3'd3,
    LD_HU   = 3'd4,
    LD_W    = 3'd5,
    LD_WL   = 3'd6,
    LD_WR   = 3'd7
  } load_op_e;

  logic            ws_valid;
  logic [PC_W-1:0] ws_pc;
  logic            ws_gr_we;
  logic [4:0]      ws_dest;
  logic [31:0]     ws_result;
  load_op_e        ws_load_op;
  logic [1:0]      ws_addr_low;
  logic [31:0]     ws_mem_rdata;

  logic            ws_ready_go;
  logic            gpr_write;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [3:0]      lane_mask;
  logic [31:0]     lane_data;

  assign ws_ready_go = ~ws_stall;
  assign ws_allowin  = ~ws_valid | ws_ready_go;

  // Flush beats a simultaneous capture for the valid bit only; the data
  // registers are allowed to load because nothing reads them while invalid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid <= 1'b0;
    end else if (ws_flush) begin
      ws_valid <= 1'b0;
    end else if (ws_allowin) begin
      ws_valid <= ms_to_ws_valid;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_pc        <= RESET_PC;
      ws_gr_we     <= 1'b0;
      ws_dest      <= '0;
      ws_result    <= '0;
      ws_load_op   <= LD_NONE;
      ws_addr_low  <= '0;
      ws_mem_rdata <= '0;
    end else if (ws_allowin && ms_to_ws_valid) begin
      ws_pc        <= ms_pc;
      ws_gr_we     <= ms_gr_we;
      ws_dest      <= ms_dest;
      ws_result    <= ms_result;
      ws_load_op   <= load_op_e'(ms_load_op);
      ws_addr_low  <= ms_addr_low;
      ws_mem_rdata <= ms_mem_rdata;
    end
  end

  assign ld_byte = ws_mem_rdata[{ws_addr_low, 3'b000} +: 8];
  assign ld_half = ws_mem_rdata[{ws_addr_low[1], 4'b0000} +: 16];

  // LWL/LWR: shift amount 3-b equals ~b on two bits.
  always_comb begin
    lane_mask = 4'b1111;
    lane_data = ws_result;
    unique case (ws_load_op)
      LD_NONE: lane_data = ws_result;
      LD_B:    lane_data = {{24{ld_byte[7]}}, ld_byte};
      LD_BU:   lane_data = {24'd0, ld_byte};
      LD_H:    lane_data = {{16{ld_half[15]}}, ld_half};
      LD_HU:   lane_data = {16'd0, ld_half};
      LD_W:    lane_data = ws_mem_rdata;
      LD_WL: begin
        lane_data = ws_mem_rdata << {~ws_addr_low, 3'b000};
        lane_mask = 4'b1111 << ~ws_addr_low;
      end
      LD_WR: begin
        lane_data = ws_mem_rdata >> {ws_addr_low, 3'b000};
        lane_mask = 4'b1111 >> ws_addr_low;
      end
    endcase
  end

  assign gpr_write = ws_valid & ws_gr_we & (ws_dest != 5'd0);

  assign rf_we    = (gpr_write & ws_ready_go) ? lane_mask : '0;
  assign rf_waddr = ws_dest;
  assign rf_wdata = lane_data;

  assign ws_fwd_valid = gpr_write;
  assign ws_fwd_dest  = gpr_write ? ws_dest : '0;
  assign ws_fwd_data  = lane_data;

  assign debug_wb_pc       = ws_pc;
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule
